// File: rtl/fp_rnd_pipe.sv
// fp_rnd_pipe: two-stage binary32 round-and-pack pipeline with valid/ready flow control.
// Define FP_RND_SUBNORMAL_EN to denormalize tiny inputs; otherwise they flush to signed zero.
module fp_rnd_pipe (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        sig,
    input  logic [9:0]  expo,
    input  logic [24:0] mant,
    input  logic [2:0]  grs,
    input  logic [2:0]  rm,
    input  logic [1:0]  fmt,
    input  logic        snan,
    input  logic        qnan,
    input  logic        dbz,
    input  logic        inf,
    input  logic        zero,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic [4:0]  flags
);
    localparam logic [31:0] QNAN_C = 32'h7FC0_0000;
    localparam logic [30:0] INF_C  = 31'h7F80_0000;
    localparam logic [30:0] MAX_C  = 31'h7F7F_FFFF;

    typedef struct packed {
        logic        sig;
        logic [2:0]  rm;
        logic [23:0] m;
        logic [10:0] e;
        logic        inc;
        logic        nx;
        logic        uf;
        logic        tiny;
        logic        spec;
        logic [31:0] spec_res;
        logic [4:0]  spec_flg;
    } s1_t;

    s1_t         s1_new, s1_d, s1_q;
    logic        s1_valid_d, s1_valid_q, s2_valid_d, s2_valid_q;
    logic [31:0] result_d, result_q, res2;
    logic [4:0]  flags_d, flags_q, flg2;
    logic        s1_adv, s2_adv;
    logic [23:0] m_a;
    logic [2:0]  grs_a, grs_b;
    logic [10:0] e_a;
    logic        tiny, inexact;
`ifdef FP_RND_SUBNORMAL_EN
    logic [10:0] sh_full;
    logic [5:0]  sh;
    logic [49:0] ext;
`endif
    logic [24:0] sum;
    logic [23:0] m2;
    logic [10:0] e2;
    logic        ovf;
    logic [7:0]  exp_f;

    // Stage 1: carry-out normalize, optional denormalize, rounding increment and special override.
    always_comb begin
        s1_new = '0;
        m_a    = mant[24] ? mant[24:1] : mant[23:0];
        grs_a  = mant[24] ? {mant[0], grs[2], grs[1] | grs[0]} : grs;
        e_a    = {expo[9], expo} + {10'd0, mant[24]};
        tiny   = e_a[10] | (e_a == 11'd0);
`ifdef FP_RND_SUBNORMAL_EN
        sh_full = 11'd1 - e_a;
        if (tiny) begin
            sh       = (sh_full > 11'd26) ? 6'd26 : sh_full[5:0];
            s1_new.e = 11'd1;
        end else begin
            sh       = 6'd0;
            s1_new.e = e_a;
        end
        ext      = {m_a, grs_a[2:1], 24'd0} >> sh;
        s1_new.m = ext[49:26];
        grs_b    = {ext[25:24], (|ext[23:0]) | grs_a[0]};
        s1_new.uf = tiny & (|grs_b);
`else
        s1_new.e  = e_a;
        s1_new.m  = m_a;
        grs_b     = grs_a;
        s1_new.uf = 1'b0;
`endif
        inexact = |grs_b;
        case (rm)
            3'd1:    s1_new.inc = 1'b0;
            3'd2:    s1_new.inc = sig & inexact;
            3'd3:    s1_new.inc = ~sig & inexact;
            3'd4:    s1_new.inc = grs_b[2];
            default: s1_new.inc = grs_b[2] & (grs_b[1] | grs_b[0] | s1_new.m[0]);
        endcase
        s1_new.sig  = sig;
        s1_new.rm   = rm;
        s1_new.nx   = inexact;
        s1_new.tiny = tiny;
        s1_new.spec = 1'b1;
        if (fmt != 2'd0) begin
            s1_new.spec_res = QNAN_C;
            s1_new.spec_flg = 5'b10000;
        end else if (snan) begin
            s1_new.spec_res = QNAN_C;
            s1_new.spec_flg = 5'b10000;
        end else if (qnan) begin
            s1_new.spec_res = QNAN_C;
            s1_new.spec_flg = 5'b00000;
        end else if (dbz) begin
            s1_new.spec_res = {sig, INF_C};
            s1_new.spec_flg = 5'b01000;
        end else if (inf) begin
            s1_new.spec_res = {sig, INF_C};
            s1_new.spec_flg = 5'b00000;
        end else if (zero) begin
            s1_new.spec_res = {sig, 31'h0};
            s1_new.spec_flg = 5'b00000;
`ifndef FP_RND_SUBNORMAL_EN
        end else if (tiny) begin
            s1_new.spec_res = {sig, 31'h0};
            s1_new.spec_flg = 5'b00011;
`endif
        end else begin
            s1_new.spec     = 1'b0;
            s1_new.spec_res = 32'h0;
            s1_new.spec_flg = 5'b00000;
        end
    end

    // Stage 2: apply increment, renormalize on carry, detect overflow and pack.
    always_comb begin
        sum = {1'b0, s1_q.m} + {24'd0, s1_q.inc};
        if (sum[24]) begin
            m2 = sum[24:1];
            e2 = s1_q.e + 11'd1;
        end else begin
            m2 = sum[23:0];
            e2 = s1_q.e;
        end
        ovf = ~e2[10] & (e2 >= 11'd255);
        // A tiny value that did not round up into bit 23 stays subnormal.
        exp_f = (s1_q.tiny & ~m2[23]) ? 8'd0 : e2[7:0];
        if (s1_q.spec) begin
            res2 = s1_q.spec_res;
            flg2 = s1_q.spec_flg;
        end else if (ovf) begin
            flg2 = 5'b00101;
            case (s1_q.rm)
                3'd1:    res2 = {s1_q.sig, MAX_C};
                3'd2:    res2 = {s1_q.sig, s1_q.sig ? INF_C : MAX_C};
                3'd3:    res2 = {s1_q.sig, s1_q.sig ? MAX_C : INF_C};
                default: res2 = {s1_q.sig, INF_C};
            endcase
        end else begin
            res2 = {s1_q.sig, exp_f, m2[22:0]};
            flg2 = {3'b000, s1_q.uf, s1_q.nx};
        end
    end

    // Pipeline advance and next-state selection.
    always_comb begin
        s2_adv = ~s2_valid_q | out_ready;
        s1_adv = ~s1_valid_q | s2_adv;
        if (s1_adv) begin
            s1_valid_d = in_valid;
            s1_d       = in_valid ? s1_new : s1_q;
        end else begin
            s1_valid_d = s1_valid_q;
            s1_d       = s1_q;
        end
        s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
        if (s2_adv & s1_valid_q) begin
            result_d = res2;
            flags_d  = flg2;
        end else begin
            result_d = result_q;
            flags_d  = flags_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_q       <= '0;
            result_q   <= 32'h0;
            flags_q    <= 5'h0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s1_q       <= s1_d;
            result_q   <= result_d;
            flags_q    <= flags_d;
        end
    end

    assign in_ready  = s1_adv;
    assign out_valid = s2_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;
endmodule

// File: tb/tb_fp_rnd_pipe.sv
// Self-checking bench for fp_rnd_pipe: directed vectors, stall/order behaviour and randomized
// records against an integer-arithmetic reference model.
module tb_fp_rnd_pipe;
    typedef struct packed {
        logic        sig;
        logic [9:0]  expo;
        logic [24:0] mant;
        logic [2:0]  grs;
        logic [2:0]  rm;
        logic [1:0]  fmt;
        logic        snan;
        logic        qnan;
        logic        dbz;
        logic        inf;
        logic        zero;
    } rec_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        sig = 1'b0;
    logic [9:0]  expo = 10'd0;
    logic [24:0] mant = 25'd0;
    logic [2:0]  grs = 3'd0;
    logic [2:0]  rm = 3'd0;
    logic [1:0]  fmt = 2'd0;
    logic        snan = 1'b0, qnan = 1'b0, dbz = 1'b0, inf = 1'b0, zero = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic [4:0]  flags;

    int vectors = 0;
    int errors  = 0;

    fp_rnd_pipe dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .sig(sig), .expo(expo), .mant(mant), .grs(grs), .rm(rm), .fmt(fmt),
        .snan(snan), .qnan(qnan), .dbz(dbz), .inf(inf), .zero(zero),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .flags(flags)
    );

    always #5 clock = ~clock;

    // Apply inputs on the falling edge, then let combinational outputs settle.
    task automatic drive(input logic v, input rec_t r, input logic ordy);
        @(negedge clock);
        in_valid  = v;
        {sig, expo, mant, grs, rm, fmt, snan, qnan, dbz, inf, zero} = r;
        out_ready = ordy;
        #1;
    endtask

    function automatic rec_t mk(input logic s, input logic [9:0] e, input logic [24:0] m,
                                input logic [2:0] g, input logic [2:0] rmode);
        rec_t r = '0;
        r.sig = s; r.expo = e; r.mant = m; r.grs = g; r.rm = rmode;
        return r;
    endfunction

    function automatic rec_t rand_rec();
        rec_t r = '0;
        int   ev;
        case ($urandom_range(0, 3))
            0:       ev = int'($urandom_range(0, 36)) - 30;
            1:       ev = 120 + int'($urandom_range(0, 15));
            2:       ev = 248 + int'($urandom_range(0, 10));
            default: ev = int'($urandom_range(0, 1023));
        endcase
        r.expo = ev[9:0];
        r.mant = {2'b01, 23'($urandom)};
        if ($signed(r.expo) > 10'sd0 && $urandom_range(0, 3) == 0) begin
            r.mant[24] = 1'b1;
            r.mant[23] = 1'($urandom);
        end
        r.grs  = 3'($urandom);
        r.rm   = 3'($urandom_range(0, 7));
        r.sig  = 1'($urandom);
        r.snan = ($urandom_range(0, 19) == 0);
        r.qnan = ($urandom_range(0, 19) == 0);
        r.dbz  = ($urandom_range(0, 19) == 0);
        r.inf  = ($urandom_range(0, 19) == 0);
        r.zero = ($urandom_range(0, 19) == 0);
        r.fmt  = ($urandom_range(0, 24) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
        return r;
    endfunction

    // Reference: exact significand as an integer with 3 fraction bits (last one sticky).
    function automatic logic [36:0] model(input rec_t r);
        logic [63:0] s, q;
        int          e, rem;
        logic        up, nx, tiny, to_inf;
        logic [7:0]  ef;
        if (r.fmt != 2'd0 || r.snan) return {32'h7FC0_0000, 5'b10000};
        if (r.qnan) return {32'h7FC0_0000, 5'b00000};
        if (r.dbz)  return {r.sig, 31'h7F80_0000, 5'b01000};
        if (r.inf)  return {r.sig, 31'h7F80_0000, 5'b00000};
        if (r.zero) return {r.sig, 31'h0, 5'b00000};
        s = {36'd0, r.mant, r.grs};
        e = int'($signed(r.expo));
        if (s >= (64'd1 << 27)) begin
            s = (s >> 1) | (s & 64'd1);
            e = e + 1;
        end
        tiny = (e <= 0);
        if (tiny) begin
`ifdef FP_RND_SUBNORMAL_EN
            int   k;
            logic lost;
            k    = (1 - e > 26) ? 26 : 1 - e;
            lost = (s & ((64'd1 << k) - 64'd1)) != 64'd0;
            s    = (s >> k) | {63'd0, lost};
            e    = 1;
`else
            return {r.sig, 31'h0, 5'b00011};
`endif
        end
        q   = s >> 3;
        rem = int'(s[2:0]);
        nx  = (rem != 0);
        case (r.rm)
            3'd1:    up = 1'b0;
            3'd2:    up = r.sig & nx;
            3'd3:    up = ~r.sig & nx;
            3'd4:    up = (rem >= 4);
            default: up = (rem > 4) || (rem == 4 && q[0]);
        endcase
        q = q + {63'd0, up};
        if (q >= (64'd1 << 24)) begin
            q = q >> 1;
            e = e + 1;
        end
        if (e >= 255) begin
            to_inf = !(r.rm == 3'd1 || (r.rm == 3'd2 && !r.sig) || (r.rm == 3'd3 && r.sig));
            return {r.sig, to_inf ? 31'h7F80_0000 : 31'h7F7F_FFFF, 5'b00101};
        end
        ef = (tiny && q < (64'd1 << 23)) ? 8'd0 : e[7:0];
        return {r.sig, ef, q[22:0], 3'b000, tiny && nx, nx};
    endfunction

    task automatic test_reset;
        reset = 1'b1;
        drive(1'b0, '0, 1'b1);
        drive(1'b0, '0, 1'b1);
        vectors++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        vectors++;
        if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected 00000000", result); end
        vectors++;
        if (flags !== 5'h0) begin errors++; $display("FAIL reset_flags: got %b expected 00000", flags); end
        reset = 1'b0;
        drive(1'b0, '0, 1'b1);
        vectors++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_reset_midop;
        rec_t r = mk(1'b0, 10'd127, 25'h0800000, 3'b000, 3'd0);
        drive(1'b1, r, 1'b1);
        drive(1'b0, r, 1'b1);
        reset = 1'b1;
        drive(1'b0, r, 1'b1);
        vectors++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL midop_reset_valid: got %b expected 0", out_valid); end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, r, 1'b1);
            vectors++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL midop_discard[%0d]: got out_valid %b expected 0", i, out_valid); end
        end
    endtask

    task automatic test_directed;
        rec_t        dv[13];
        logic [31:0] dres[13];
        logic [4:0]  dflg[13];
        dv[0]  = mk(1'b0, 10'd127, 25'h0800000, 3'b000, 3'd0); dres[0]  = 32'h3F80_0000; dflg[0]  = 5'b00000;
        dv[1]  = mk(1'b0, 10'd127, 25'h0800001, 3'b100, 3'd0); dres[1]  = 32'h3F80_0002; dflg[1]  = 5'b00001;
        dv[2]  = mk(1'b0, 10'd127, 25'h0800001, 3'b100, 3'd1); dres[2]  = 32'h3F80_0001; dflg[2]  = 5'b00001;
        dv[3]  = mk(1'b0, 10'd127, 25'h0FFFFFF, 3'b110, 3'd0); dres[3]  = 32'h4000_0000; dflg[3]  = 5'b00001;
        dv[4]  = mk(1'b0, 10'd254, 25'h0FFFFFF, 3'b100, 3'd0); dres[4]  = 32'h7F80_0000; dflg[4]  = 5'b00101;
        dv[5]  = mk(1'b0, 10'd254, 25'h0FFFFFF, 3'b100, 3'd1); dres[5]  = 32'h7F7F_FFFF; dflg[5]  = 5'b00001;
        dv[6]  = mk(1'b0, 10'd127, 25'h0800000, 3'b000, 3'd0); dv[6].snan = 1'b1; dv[6].dbz = 1'b1;
        dres[6] = 32'h7FC0_0000; dflg[6] = 5'b10000;
        dv[7]  = mk(1'b1, 10'd127, 25'h0800000, 3'b000, 3'd0); dv[7].dbz = 1'b1;
        dres[7] = 32'hFF80_0000; dflg[7] = 5'b01000;
        dv[8]  = mk(1'b0, 10'd0, 25'h0C00000, 3'b000, 3'd1);
`ifdef FP_RND_SUBNORMAL_EN
        dres[8] = 32'h0060_0000; dflg[8] = 5'b00000;
`else
        dres[8] = 32'h0000_0000; dflg[8] = 5'b00011;
`endif
        dv[9]  = mk(1'b0, 10'd127, 25'h0800000, 3'b000, 3'd0); dv[9].fmt = 2'd1;
        dres[9] = 32'h7FC0_0000; dflg[9] = 5'b10000;
        dv[10] = mk(1'b1, 10'd254, 25'h0FFFFFF, 3'b100, 3'd2); dres[10] = 32'hFF80_0000; dflg[10] = 5'b00101;
        dv[11] = mk(1'b1, 10'd255, 25'h0800000, 3'b000, 3'd3); dres[11] = 32'hFF7F_FFFF; dflg[11] = 5'b00101;
        dv[12] = mk(1'b1, 10'd127, 25'h0800000, 3'b000, 3'd0); dv[12].zero = 1'b1;
        dres[12] = 32'h8000_0000; dflg[12] = 5'b00000;
        for (int i = 0; i < 13; i++) begin
            drive(1'b1, dv[i], 1'b1);
            vectors++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL directed[%0d] in_ready: got %b expected 1", i, in_ready); end
            drive(1'b0, dv[i], 1'b1);
            vectors++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL directed[%0d] early_valid: got %b expected 0", i, out_valid); end
            drive(1'b0, dv[i], 1'b1);
            vectors++;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL directed[%0d] latency_valid: got %b expected 1", i, out_valid); end
            vectors++;
            if (result !== dres[i]) begin errors++; $display("FAIL directed[%0d] result: got %h expected %h", i, result, dres[i]); end
            vectors++;
            if (flags !== dflg[i]) begin errors++; $display("FAIL directed[%0d] flags: got %b expected %b", i, flags, dflg[i]); end
        end
    endtask

    task automatic test_back_to_back;
        rec_t r[4];
        int   acc = 0;
        int   got = 0;
        for (int i = 0; i < 4; i++) r[i] = rand_rec();
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            drive(acc < 4, r[acc % 4], cyc >= 5);
            if (cyc == 2) begin
                vectors++;
                if (acc != 2) begin errors++; $display("FAIL b2b_accepted: got %0d expected 2", acc); end
            end
            if (cyc >= 2 && cyc <= 4) begin
                vectors++;
                if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_in_ready[%0d]: got %b expected 0", cyc, in_ready); end
                vectors++;
                if (out_valid !== 1'b1 || {result, flags} !== model(r[0])) begin
                    errors++;
                    $display("FAIL b2b_hold[%0d]: got valid %b %h/%b expected 1 %h", cyc, out_valid, result, flags, model(r[0]));
                end
            end
            if (out_valid && out_ready) begin
                vectors++;
                if ({result, flags} !== model(r[got])) begin
                    errors++;
                    $display("FAIL b2b_out[%0d]: got %h/%b expected %h", got, result, flags, model(r[got]));
                end
                got++;
            end
            if (in_valid && in_ready) acc++;
        end
        vectors++;
        if (got != 4) begin errors++; $display("FAIL b2b_count: got %0d outputs expected 4", got); end
    endtask

    task automatic test_random;
        logic [36:0] exp_q[$];
        logic [36:0] prev_out = '0;
        logic        prev_stall = 1'b0;
        rec_t        cur = '0;
        logic        cur_v = 1'b0;
        int          sent = 0;
        int          recv = 0;
        localparam int N = 400;
        for (int cyc = 0; cyc < 20000 && recv < N; cyc++) begin
            if (!cur_v && sent < N && $urandom_range(0, 3) != 0) begin
                cur   = rand_rec();
                cur_v = 1'b1;
            end
            drive(cur_v, cur, $urandom_range(0, 3) != 0);
            if (prev_stall) begin
                vectors++;
                if (out_valid !== 1'b1 || {result, flags} !== prev_out) begin
                    errors++;
                    $display("FAIL rand_hold: got valid %b %h/%b expected 1 %h", out_valid, result, flags, prev_out);
                end
            end
            if (out_valid && out_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_spurious: got %h/%b expected no output", result, flags);
                end else if ({result, flags} !== exp_q[0]) begin
                    errors++;
                    $display("FAIL rand_out[%0d]: got %h/%b expected %h", recv, result, flags, exp_q[0]);
                    void'(exp_q.pop_front());
                end else begin
                    void'(exp_q.pop_front());
                end
                recv++;
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = {result, flags};
            if (cur_v && in_ready) begin
                exp_q.push_back(model(cur));
                sent++;
                cur_v = 1'b0;
            end
        end
        vectors++;
        if (recv != N || exp_q.size() != 0) begin
            errors++;
            $display("FAIL rand_count: got %0d outputs (%0d pending) expected %0d", recv, exp_q.size(), N);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_midop();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
